// File: rtl/mul_share_pkg.sv
// Shared types and Q2.13 constants for the MHA multiplier-sharing arbiter.
package mul_share_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam int          DATA_W_DEF = 16;
  localparam int          Q_FRAC     = 13;
  localparam logic [15:0] Q_ONE      = 16'h2000;

endpackage

// File: rtl/mul_share_arb_rr_pick.sv
// Combinational round-robin picker: the first set request strictly after the
// pointer, wrapping modulo N, wins.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  localparam int           CW      = IDX_W + 1;
  localparam logic [N-1:0] ONE_LSB = {{(N-1){1'b0}}, 1'b1};

  logic [CW-1:0]    sum_s;
  logic [CW-1:0]    cand_s;
  logic [IDX_W-1:0] slot_s;
  logic             hit_s;

  // Scan the N candidates in priority order; only the first hit is kept.
  always_comb begin
    gnt_o  = '0;
    idx_o  = '0;
    any_o  = 1'b0;
    sum_s  = '0;
    cand_s = '0;
    slot_s = '0;
    hit_s  = 1'b0;
    for (int k = 1; k <= N; k++) begin
      sum_s  = {1'b0, ptr_i} + CW'(k);
      cand_s = (sum_s >= CW'(N)) ? (sum_s - CW'(N)) : sum_s;
      slot_s = cand_s[IDX_W-1:0];
      hit_s  = !any_o && req_i[slot_s];
      gnt_o  = hit_s ? (ONE_LSB << slot_s) : gnt_o;
      idx_o  = hit_s ? slot_s : idx_o;
      any_o  = any_o | hit_s;
    end
  end

endmodule

// File: rtl/mul_share_arb.sv
// Shares one iterative Q2.13 multiplier among N_REQ requesters: round-robin
// grant, single outstanding op, product routed back to its owner, watchdog abort.
module mul_share_arb
  import mul_share_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 64
) (
  input  logic                    I_CLK,
  input  logic                    I_SYNC_RST,
  input  logic [N_REQ-1:0]        I_REQ,
  input  logic [N_REQ*DATA_W-1:0] I_M1,
  input  logic [N_REQ*DATA_W-1:0] I_M2,
  output logic [N_REQ-1:0]        O_GNT,
  output logic [N_REQ-1:0]        O_RSP_VLD,
  output logic [DATA_W-1:0]       O_RSP_PRODUCT,
  output logic                    O_RSP_ERR,
  output logic                    O_BUSY,
  output logic                    O_MUL_VLD,
  output logic [DATA_W-1:0]       O_MUL_M1,
  output logic [DATA_W-1:0]       O_MUL_M2,
  input  logic                    I_MUL_VLD,
  input  logic [DATA_W-1:0]       I_MUL_PRODUCT
);

  localparam int               IDX_W   = $clog2(N_REQ);
  localparam int               CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [N_REQ-1:0] ONE_LSB = {{(N_REQ-1){1'b0}}, 1'b1};

  state_e              state_q,    state_d;
  logic [IDX_W-1:0]    ptr_q,      ptr_d;
  logic [IDX_W-1:0]    owner_q,    owner_d;
  logic [CNT_W-1:0]    cnt_q,      cnt_d;
  logic [DATA_W-1:0]   m1_q,       m1_d;
  logic [DATA_W-1:0]   m2_q,       m2_d;
  logic [N_REQ-1:0]    gnt_q,      gnt_d;
  logic                mul_vld_q,  mul_vld_d;
  logic [N_REQ-1:0]    rsp_vld_q,  rsp_vld_d;
  logic [DATA_W-1:0]   rsp_prod_q, rsp_prod_d;
  logic                rsp_err_q,  rsp_err_d;
  logic                busy_q,     busy_d;

  logic [N_REQ-1:0]    pick_gnt_s;
  logic [IDX_W-1:0]    pick_idx_s;
  logic                pick_any_s;
  logic [N_REQ-1:0]    owner_oh_s;

  rr_pick #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i (I_REQ),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt_s),
    .idx_o (pick_idx_s),
    .any_o (pick_any_s)
  );

  assign owner_oh_s = ONE_LSB << owner_q;

  // Next-state and registered-output decode for the single-op FSM.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    m1_d       = m1_q;
    m2_d       = m2_q;
    gnt_d      = '0;
    mul_vld_d  = 1'b0;
    rsp_vld_d  = '0;
    rsp_prod_d = '0;
    rsp_err_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any_s) begin
          state_d   = ST_ISSUE;
          gnt_d     = pick_gnt_s;
          owner_d   = pick_idx_s;
          ptr_d     = pick_idx_s;
          m1_d      = I_M1[pick_idx_s*DATA_W +: DATA_W];
          m2_d      = I_M2[pick_idx_s*DATA_W +: DATA_W];
          mul_vld_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A product arriving on the last allowed cycle beats the watchdog.
        if (I_MUL_VLD) begin
          state_d    = ST_RESP;
          rsp_vld_d  = owner_oh_s;
          rsp_prod_d = I_MUL_PRODUCT;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d   = ST_RESP;
          rsp_vld_d = owner_oh_s;
          rsp_err_d = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset leaves requester 0 with first priority.
  always_ff @(posedge I_CLK) begin
    if (I_SYNC_RST) begin
      state_q    <= ST_IDLE;
      ptr_q      <= IDX_W'(N_REQ - 1);
      owner_q    <= '0;
      cnt_q      <= '0;
      m1_q       <= '0;
      m2_q       <= '0;
      gnt_q      <= '0;
      mul_vld_q  <= 1'b0;
      rsp_vld_q  <= '0;
      rsp_prod_q <= '0;
      rsp_err_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      m1_q       <= m1_d;
      m2_q       <= m2_d;
      gnt_q      <= gnt_d;
      mul_vld_q  <= mul_vld_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_prod_q <= rsp_prod_d;
      rsp_err_q  <= rsp_err_d;
      busy_q     <= busy_d;
    end
  end

  assign O_GNT         = gnt_q;
  assign O_RSP_VLD     = rsp_vld_q;
  assign O_RSP_PRODUCT = rsp_prod_q;
  assign O_RSP_ERR     = rsp_err_q;
  assign O_BUSY        = busy_q;
  assign O_MUL_VLD     = mul_vld_q;
  assign O_MUL_M1      = m1_q;
  assign O_MUL_M2      = m2_q;

endmodule

// File: tb/tb_mul_share_arb.sv
// Bench for mul_share_arb: directed scenarios plus randomized traffic, with a
// behavioural multiplier and a round-robin / Q2.13 reference model.
module tb_mul_share_arb;
  import mul_share_pkg::*;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int TO = 64;

  logic             clk = 1'b0;
  logic             srst;
  logic [N-1:0]     req;
  logic [N*W-1:0]   m1, m2;
  logic [N-1:0]     gnt, rsp_vld;
  logic [W-1:0]     rsp_prod;
  logic             rsp_err, busy, mul_vld_o;
  logic [W-1:0]     mul_m1, mul_m2;
  logic             mul_vld_i;
  logic [W-1:0]     mul_prod_i;

  int               errors = 0;
  int               checks = 0;
  int               cyc = 0;
  logic [W-1:0]     a [N];
  logic [W-1:0]     b [N];
  int               mul_lat = 4;
  bit               mul_hang = 1'b0;
  bit               mul_pend = 1'b0;
  int               mul_cd = 0;
  logic [W-1:0]     mul_a, mul_b;
  int               issue_cyc = 0;
  int               mul_pulses = 0;
  int               rsp_pulses = 0;
  logic [N-1:0]     gnt_or = '0;
  bit               busy_seen = 1'b0;
  int               rr_ref = N - 1;

  mul_share_arb #(.N_REQ(N), .DATA_W(W), .TIMEOUT(TO)) dut (
    .I_CLK         (clk),
    .I_SYNC_RST    (srst),
    .I_REQ         (req),
    .I_M1          (m1),
    .I_M2          (m2),
    .O_GNT         (gnt),
    .O_RSP_VLD     (rsp_vld),
    .O_RSP_PRODUCT (rsp_prod),
    .O_RSP_ERR     (rsp_err),
    .O_BUSY        (busy),
    .O_MUL_VLD     (mul_vld_o),
    .O_MUL_M1      (mul_m1),
    .O_MUL_M2      (mul_m2),
    .I_MUL_VLD     (mul_vld_i),
    .I_MUL_PRODUCT (mul_prod_i)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "time limit");
  end

  // Q2.13 product: sign bit plus bits [27:13] of the full 32-bit product.
  function automatic logic [W-1:0] q_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic signed [31:0] f;
    f = $signed(x) * $signed(y);
    return {f[31], f[Q_FRAC+14:Q_FRAC]};
  endfunction

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] one;
    one = 1;
    return one << i;
  endfunction

  function automatic int rr_winner(input logic [N-1:0] m, input int p);
    for (int k = 1; k <= N; k++) begin
      if (m[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_ops();
    for (int i = 0; i < N; i++) begin
      m1[i*W +: W] = a[i];
      m2[i*W +: W] = b[i];
    end
  endtask

  // One clock: sample outputs #1 after the edge, then run the multiplier model.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    mul_vld_i  = 1'b0;
    mul_prod_i = '0;
    gnt_or     = gnt_or | gnt;
    if (rsp_vld != '0) rsp_pulses++;
    if (busy) busy_seen = 1'b1;
    if (mul_vld_o) begin
      mul_pulses++;
      issue_cyc = cyc;
      mul_pend  = 1'b1;
      mul_cd    = mul_lat;
      mul_a     = mul_m1;
      mul_b     = mul_m2;
    end else if (mul_pend && !mul_hang) begin
      mul_cd--;
      if (mul_cd <= 0) begin
        mul_vld_i  = 1'b1;
        mul_prod_i = q_mul(mul_a, mul_b);
        mul_pend   = 1'b0;
      end
    end
  endtask

  task automatic wait_gnt(input int max_cyc, output logic [N-1:0] g);
    int n = 0;
    g = '0;
    while (g == '0 && n < max_cyc) begin
      tick();
      n++;
      g = gnt;
    end
  endtask

  task automatic wait_rsp(input int max_cyc, output logic [N-1:0] v,
                          output logic [W-1:0] p, output logic e);
    int n = 0;
    v = '0;
    p = '0;
    e = 1'b0;
    while (v == '0 && n < max_cyc) begin
      tick();
      n++;
      if (rsp_vld != '0) begin
        v = rsp_vld;
        p = rsp_prod;
        e = rsp_err;
      end
    end
  endtask

  initial begin
    logic [N-1:0] g, v, mask;
    logic [W-1:0] p, ep;
    logic         e, exp_e;
    int           w;

    srst = 1'b1; req = '0; m1 = '0; m2 = '0; mul_vld_i = 1'b0; mul_prod_i = '0;
    for (int i = 0; i < N; i++) begin
      a[i] = '0;
      b[i] = '0;
    end
    tick();
    tick();
    chk("rst_gnt", gnt, 0);
    chk("rst_rsp_vld", rsp_vld, 0);
    chk("rst_flags", {rsp_err, busy, mul_vld_o}, 0);
    chk("rst_data", {rsp_prod, mul_m1}, 0);
    srst = 1'b0;
    tick();

    // Single op: unity times unity.
    a[0] = Q_ONE; b[0] = Q_ONE; drive_ops();
    mul_lat = 16; mul_pulses = 0;
    req = 4'b0001;
    tick();
    chk("t1_gnt", gnt, 4'b0001);
    chk("t1_mul_vld", mul_vld_o, 1);
    chk("t1_busy", busy, 1);
    req = '0; rr_ref = 0;
    wait_rsp(200, v, p, e);
    chk("t1_rsp_vld", v, 4'b0001);
    chk("t1_prod", p, 16'h2000);
    chk("t1_err", e, 0);
    chk("t1_mul_pulses", mul_pulses, 1);

    // Signed: 2.0 * -1.0.
    a[2] = 16'h4000; b[2] = 16'hE000; drive_ops();
    mul_lat = 5;
    req = 4'b0100;
    wait_gnt(5, g);
    chk("t2_gnt", g, 4'b0100);
    req = '0; rr_ref = 2;
    wait_rsp(200, v, p, e);
    chk("t2_rsp_vld", v, 4'b0100);
    chk("t2_prod", p, 16'hC000);
    chk("t2_err", e, 0);

    // Fairness: everyone requesting after reset -> 0,1,2,3,0,1,2,3.
    srst = 1'b1; tick(); srst = 1'b0; rr_ref = N - 1;
    for (int i = 0; i < N; i++) begin
      a[i] = W'($urandom);
      b[i] = W'($urandom);
    end
    drive_ops();
    mul_lat = 3;
    req = 4'b1111;
    for (int op = 0; op < 8; op++) begin
      wait_gnt(10, g);
      w = op % N;
      chk("fair_gnt", g, oh(w));
      chk("fair_m1", mul_m1, a[w]);
      rr_ref = w;
      ep = q_mul(a[w], b[w]);
      a[w] = W'($urandom);
      b[w] = W'($urandom);
      drive_ops();
      wait_rsp(100, v, p, e);
      chk("fair_rsp_vld", v, oh(w));
      chk("fair_prod", p, ep);
    end
    req = '0;

    // Watchdog boundary: valid on the last WAIT cycle wins, one later times out.
    for (int lat = TO; lat <= TO + 1; lat++) begin
      a[1] = W'($urandom); b[1] = W'($urandom); drive_ops();
      mul_lat = lat;
      req = 4'b0010;
      wait_gnt(5, g);
      chk("lat_gnt", g, 4'b0010);
      req = '0; rr_ref = 1;
      ep = q_mul(a[1], b[1]);
      exp_e = (lat - 1 > TO - 1);
      wait_rsp(200, v, p, e);
      chk("lat_rsp_vld", v, 4'b0010);
      chk("lat_err", e, exp_e);
      chk("lat_prod", p, exp_e ? 16'h0000 : ep);
      chk("lat_cycles", cyc - issue_cyc, TO + 1);
    end

    // Hung multiplier, then normal service resumes.
    mul_hang = 1'b1;
    req = 4'b0100;
    wait_gnt(5, g);
    chk("hang_gnt", g, 4'b0100);
    req = '0; rr_ref = 2;
    wait_rsp(200, v, p, e);
    chk("hang_rsp_vld", v, 4'b0100);
    chk("hang_err", e, 1);
    chk("hang_prod", p, 0);
    chk("hang_cycles", cyc - issue_cyc, TO + 1);
    mul_hang = 1'b0;
    a[3] = W'($urandom); b[3] = W'($urandom); drive_ops();
    mul_lat = 5;
    req = 4'b1000;
    wait_gnt(5, g);
    chk("post_hang_gnt", g, 4'b1000);
    req = '0; rr_ref = 3;
    ep = q_mul(a[3], b[3]);
    wait_rsp(100, v, p, e);
    chk("post_hang_rsp", {v, p, e}, {4'b1000, ep, 1'b0});

    // Reset during WAIT: abort, ignore the late product, restart at requester 0.
    mul_lat = 20;
    req = 4'b0100;
    wait_gnt(5, g);
    chk("rmid_gnt", g, 4'b0100);
    req = '0;
    repeat (5) tick();
    srst = 1'b1;
    tick();
    chk("rmid_ctrl", {gnt, rsp_vld, rsp_err, busy, mul_vld_o}, 0);
    chk("rmid_data", {rsp_prod, mul_m1, mul_m2}, 0);
    srst = 1'b0; rr_ref = N - 1;
    rsp_pulses = 0; busy_seen = 1'b0;
    repeat (30) tick();
    chk("rmid_no_rsp", rsp_pulses, 0);
    chk("rmid_idle", busy_seen, 0);
    mul_lat = 4;
    req = 4'b1111;
    tick();
    chk("rmid_next_gnt", gnt, oh(rr_winner(4'b1111, rr_ref)));
    req = '0; rr_ref = 0;
    ep = q_mul(a[0], b[0]);
    wait_rsp(100, v, p, e);
    chk("rmid_next_rsp", {v, p}, {4'b0001, ep});

    // Withdrawn request is never granted; spurious valid in IDLE is ignored.
    mul_lat = 10;
    req = 4'b1000;
    wait_gnt(5, g);
    chk("wd_gnt", g, 4'b1000);
    rr_ref = 3;
    req = 4'b0010; gnt_or = '0;
    repeat (3) tick();
    req = '0;
    wait_rsp(100, v, p, e);
    chk("wd_rsp_vld", v, 4'b1000);
    repeat (4) tick();
    chk("wd_no_gnt", gnt_or, 0);
    rsp_pulses = 0; busy_seen = 1'b0;
    mul_vld_i = 1'b1; mul_prod_i = 16'h1234;
    repeat (3) tick();
    chk("spur_no_rsp", rsp_pulses, 0);
    chk("spur_idle", busy_seen, 0);

    // Randomized traffic against the round-robin reference.
    for (int op = 0; op < 40; op++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        a[i] = W'($urandom);
        b[i] = W'($urandom);
      end
      drive_ops();
      mul_lat = $urandom_range(1, 12);
      req = mask;
      w = rr_winner(mask, rr_ref);
      wait_gnt(6, g);
      chk("rnd_gnt", g, oh(w));
      rr_ref = w;
      ep = q_mul(a[w], b[w]);
      req = '0;
      wait_rsp(100, v, p, e);
      chk("rnd_rsp_vld", v, oh(w));
      chk("rnd_prod", p, ep);
      chk("rnd_err", e, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
